// File: rtl/framebuffer_scanout.sv
// Colour framebuffer fed by the plot interface, with a full-screen hardware clear
// and a continuous raster scanout producing a registered pixel stream.
module framebuffer_scanout #(
  parameter int         WIDTH        = 160,
  parameter int         HEIGHT       = 120,
  parameter int         H_BLANK      = 40,
  parameter int         V_BLANK      = 5,
  parameter logic [2:0] CLEAR_COLOUR = 3'b111
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  input  logic       clear_req,
  output logic       busy,
  output logic       oob_err,
  output logic       wr_dropped,
  output logic       pix_valid,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic [2:0] pix_colour,
  output logic       frame_start
);

  localparam int          DEPTH      = WIDTH * HEIGHT;
  localparam logic [7:0]  X_LIM      = 8'(WIDTH);
  localparam logic [6:0]  Y_LIM      = 7'(HEIGHT);
  localparam logic [7:0]  H_LAST     = 8'(WIDTH + H_BLANK - 1);
  localparam logic [6:0]  V_LAST     = 7'(HEIGHT + V_BLANK - 1);
  localparam logic [14:0] SWEEP_LAST = 15'(DEPTH - 1);
  localparam logic [14:0] ROW_STRIDE = 15'(WIDTH);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t      state_r, next_state_s;
  logic [14:0] sweep_r;
  logic        busy_r, oob_r, dropped_r;
  logic [7:0]  h_r;
  logic [6:0]  v_r;
  logic        pix_valid_r, frame_start_r;
  logic [7:0]  pix_x_r;
  logic [6:0]  pix_y_r;
  logic [2:0]  pix_colour_r;
  logic [2:0]  mem_r [DEPTH];

  logic        busy_s, in_range_s, plot_ok_s, we_s, rd_en_s;
  logic [14:0] wr_addr_s, rd_addr_s;
  logic [2:0]  wr_data_s;

  function automatic logic [14:0] pix_addr(input logic [7:0] col, input logic [6:0] row);
    return ({8'd0, row} * ROW_STRIDE) + {7'd0, col};
  endfunction

  assign in_range_s = (x < X_LIM) && (y < Y_LIM);
  // A clear request in the same cycle takes priority over the plot.
  assign plot_ok_s  = plot && !clear_req && in_range_s;
  assign rd_en_s    = (h_r < X_LIM) && (v_r < Y_LIM);
  assign rd_addr_s  = pix_addr(h_r, v_r);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) state_r <= IDLE;
    else         state_r <= next_state_s;
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (clear_req) next_state_s = CLEAR;
        else           next_state_s = IDLE;
      end
      CLEAR: begin
        if (sweep_r == SWEEP_LAST) next_state_s = IDLE;
        else                       next_state_s = CLEAR;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs: shared write port mux and next value of busy
  always_comb begin
    busy_s    = 1'b0;
    we_s      = 1'b0;
    wr_addr_s = 15'd0;
    wr_data_s = 3'd0;
    case (state_r)
      IDLE: begin
        busy_s = clear_req;
        if (plot_ok_s) begin
          we_s      = 1'b1;
          wr_addr_s = pix_addr(x, y);
          wr_data_s = colour;
        end else begin
          we_s      = 1'b0;
        end
      end
      CLEAR: begin
        busy_s    = (sweep_r != SWEEP_LAST);
        we_s      = 1'b1;
        wr_addr_s = sweep_r;
        wr_data_s = CLEAR_COLOUR;
      end
      default: begin
        busy_s = 1'b0;
        we_s   = 1'b0;
      end
    endcase
  end

  // Sweep counter, busy and sticky error flags
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sweep_r   <= 15'd0;
      busy_r    <= 1'b0;
      oob_r     <= 1'b0;
      dropped_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      if (state_r == CLEAR) sweep_r <= sweep_r + 15'd1;
      else                  sweep_r <= 15'd0;
      if (plot && (state_r == IDLE) && !clear_req && !in_range_s) oob_r <= 1'b1;
      if (plot && ((state_r == CLEAR) || clear_req)) dropped_r <= 1'b1;
    end
  end

  // RAM write port; no write on a reset edge so an aborted sweep stops cleanly
  always_ff @(posedge clk) begin
    if (resetn && we_s) mem_r[wr_addr_s] <= wr_data_s;
  end

  // Raster counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      h_r <= 8'd0;
      v_r <= 7'd0;
    end else if (h_r == H_LAST) begin
      h_r <= 8'd0;
      if (v_r == V_LAST) v_r <= 7'd0;
      else               v_r <= v_r + 7'd1;
    end else begin
      h_r <= h_r + 8'd1;
    end
  end

  // Registered read and pixel stream; a same-cycle write returns the old word
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pix_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      pix_x_r       <= 8'd0;
      pix_y_r       <= 7'd0;
      pix_colour_r  <= 3'd0;
    end else begin
      pix_valid_r   <= rd_en_s;
      frame_start_r <= rd_en_s && (h_r == 8'd0) && (v_r == 7'd0);
      if (rd_en_s) begin
        pix_x_r      <= h_r;
        pix_y_r      <= v_r;
        pix_colour_r <= mem_r[rd_addr_s];
      end
    end
  end

  assign busy        = busy_r;
  assign oob_err     = oob_r;
  assign wr_dropped  = dropped_r;
  assign pix_valid   = pix_valid_r;
  assign pix_x       = pix_x_r;
  assign pix_y       = pix_y_r;
  assign pix_colour  = pix_colour_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout: a reference RAM/raster model pushes the
// expected pixel on every read; each cycle the DUT stream is popped and compared.
module tb_framebuffer_scanout;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int HT    = 200;
  localparam int VT    = 125;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       clear_req;
  logic       busy, oob_err, wr_dropped, pix_valid, frame_start;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;

  framebuffer_scanout dut (
    .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
    .clear_req(clear_req), .busy(busy), .oob_err(oob_err), .wr_dropped(wr_dropped),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
    bit         known;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] mem_m   [W*H];
  bit         known_m [W*H];
  int         h_m, v_m, clr_addr_m;
  bit         clr_on_m;

  int checks = 0, failures = 0, cyc = 0;
  int last_fs = -1, run_len = 0, line_cnt = 0, bad_runs = 0;
  int gap_q[$], lines_q[$];

  function automatic int midx(int col, int row);
    return row * W + col;
  endfunction

  // Reference model: raster position, RAM contents and clear sweep
  always @(posedge clk) begin
    if (resetn !== 1'b1) begin
      h_m        <= 0;
      v_m        <= 0;
      clr_on_m   <= 1'b0;
      clr_addr_m <= 0;
    end else begin
      if (h_m < W && v_m < H)
        exp_q.push_back('{8'(h_m), 7'(v_m), mem_m[midx(h_m, v_m)], known_m[midx(h_m, v_m)]});
      if (h_m == HT - 1) begin
        h_m <= 0;
        v_m <= (v_m == VT - 1) ? 0 : v_m + 1;
      end else begin
        h_m <= h_m + 1;
      end
      if (clr_on_m) begin
        mem_m[clr_addr_m]   <= 3'b111;
        known_m[clr_addr_m] <= 1'b1;
        if (clr_addr_m == W * H - 1) clr_on_m <= 1'b0;
        clr_addr_m <= clr_addr_m + 1;
      end else if (clear_req === 1'b1) begin
        clr_on_m   <= 1'b1;
        clr_addr_m <= 0;
      end else if (plot === 1'b1 && int'(x) < W && int'(y) < H) begin
        mem_m[midx(int'(x), int'(y))]   <= colour;
        known_m[midx(int'(x), int'(y))] <= 1'b1;
      end
    end
  end

  // Advance one cycle, then compare the DUT pixel stream with the scoreboard
  task automatic sb_cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (pix_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_empty cyc=%0d got x=%0d y=%0d", cyc, pix_x, pix_y);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (pix_x !== e.px || pix_y !== e.py || (e.known && pix_colour !== e.pc) ||
            frame_start !== (e.px == 8'd0 && e.py == 7'd0)) begin
          failures++;
          $display("FAIL pixel cyc=%0d got x=%0d y=%0d c=%b fs=%b, exp x=%0d y=%0d c=%b known=%0d",
                   cyc, pix_x, pix_y, pix_colour, frame_start, e.px, e.py, e.pc, e.known);
        end
      end
    end else begin
      checks++;
      if (frame_start !== 1'b0 || exp_q.size() != 0) begin
        failures++;
        $display("FAIL missing_pixel cyc=%0d got valid=%b fs=%b, exp valid=1 pending=%0d",
                 cyc, pix_valid, frame_start, exp_q.size());
        exp_q.delete();
      end
    end
    if (pix_valid === 1'b1) begin
      run_len++;
    end else if (run_len != 0) begin
      line_cnt++;
      if (run_len != W) bad_runs++;
      run_len = 0;
    end
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) begin
        gap_q.push_back(cyc - last_fs);
        lines_q.push_back(line_cnt);
      end
      last_fs  = cyc;
      line_cnt = 0;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; plot = 1'b0; clear_req = 1'b0;
    x = 8'd0; y = 7'd0; colour = 3'd0;
    repeat (3) sb_cycle();
    checks++;
    if ({busy, oob_err, wr_dropped, pix_valid, frame_start} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00000", {busy, oob_err, wr_dropped, pix_valid, frame_start});
    end
    checks++;
    if (pix_x !== 8'd0 || pix_y !== 7'd0 || pix_colour !== 3'd0) begin
      failures++;
      $display("FAIL reset_pix got x=%0d y=%0d c=%b exp 0 0 000", pix_x, pix_y, pix_colour);
    end
    resetn = 1'b1;
  endtask

  task automatic test_clear();
    int cnt;
    clear_req = 1'b1;
    sb_cycle();
    clear_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 20000) begin
      cnt++;
      if (cnt == 300) begin
        checks++;
        if (wr_dropped !== 1'b0) begin
          failures++; $display("FAIL dropped_early got=%b exp=0", wr_dropped);
        end
      end
      plot = (cnt == 300); clear_req = (cnt == 600);
      x = 8'd3; y = 7'd3; colour = 3'b000;
      sb_cycle();
    end
    plot = 1'b0; clear_req = 1'b0;
    checks++;
    if (cnt != W * H) begin
      failures++; $display("FAIL busy_length got=%0d exp=%0d", cnt, W * H);
    end
    checks++;
    if (wr_dropped !== 1'b1 || oob_err !== 1'b0) begin
      failures++; $display("FAIL dropped_flag got drop=%b oob=%b exp drop=1 oob=0", wr_dropped, oob_err);
    end
  endtask

  task automatic test_clear_frame();
    int nvalid = 0, n111 = 0;
    for (int i = 0; i < 26000 && frame_start !== 1'b1; i++) sb_cycle();
    checks++;
    if (frame_start !== 1'b1) begin
      failures++; $display("FAIL clear_frame_wait got fs=%b exp=1", frame_start);
    end
    for (int i = 0; i < 24000; i++) begin
      if (pix_valid === 1'b1) begin
        nvalid++;
        if (pix_colour === 3'b111) n111++;
      end
      sb_cycle();
    end
    checks++;
    if (nvalid != W * H || n111 != W * H) begin
      failures++; $display("FAIL clear_frame got valid=%0d white=%0d exp %0d", nvalid, n111, W * H);
    end
  endtask

  task automatic test_write();
    plot = 1'b1; x = 8'd5; y = 7'd7; colour = 3'b010;
    sb_cycle();
    plot = 1'b0;
  endtask

  task automatic test_oob();
    checks++;
    if (oob_err !== 1'b0) begin
      failures++; $display("FAIL oob_before got=%b exp=0", oob_err);
    end
    plot = 1'b1; x = 8'd160; y = 7'd0; colour = 3'b101;
    sb_cycle();
    checks++;
    if (oob_err !== 1'b1) begin
      failures++; $display("FAIL oob_after_x got=%b exp=1", oob_err);
    end
    x = 8'd0; y = 7'd120;
    sb_cycle();
    plot = 1'b0;
    sb_cycle();
    checks++;
    if (oob_err !== 1'b1) begin
      failures++; $display("FAIL oob_sticky got=%b exp=1", oob_err);
    end
  endtask

  task automatic test_readback();
    logic [2:0] c01 = 3'b000;
    bit seen01 = 1'b0;
    int i;
    for (i = 0; i < 2000 && frame_start !== 1'b1; i++) sb_cycle();
    for (i = 0; i < 2000 && !(pix_valid === 1'b1 && pix_x === 8'd5 && pix_y === 7'd7); i++) begin
      sb_cycle();
      if (pix_valid === 1'b1 && pix_x === 8'd0 && pix_y === 7'd1) begin
        c01 = pix_colour; seen01 = 1'b1;
      end
    end
    checks++;
    if (pix_valid !== 1'b1 || pix_colour !== 3'b010) begin
      failures++; $display("FAIL readback got valid=%b c=%b exp valid=1 c=010", pix_valid, pix_colour);
    end
    checks++;
    if (cyc - last_fs != 7 * HT + 5) begin
      failures++; $display("FAIL readback_timing got=%0d exp=%0d", cyc - last_fs, 7 * HT + 5);
    end
    checks++;
    if (!seen01 || c01 !== 3'b111) begin
      failures++; $display("FAIL oob_alias got seen=%0d c=%b exp seen=1 c=111", seen01, c01);
    end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 26000 && !(h_m == 10 && v_m == 20); i++) sb_cycle();
    plot = 1'b1; x = 8'd10; y = 7'd20; colour = 3'b001;
    sb_cycle();
    plot = 1'b0;
    checks++;
    if (pix_valid !== 1'b1 || pix_x !== 8'd10 || pix_y !== 7'd20 || pix_colour !== 3'b111) begin
      failures++;
      $display("FAIL collision_old got v=%b x=%0d y=%0d c=%b exp 1 10 20 111", pix_valid, pix_x, pix_y, pix_colour);
    end
  endtask

  task automatic test_timing();
    for (int i = 0; i < 26000 && frame_start !== 1'b1; i++) sb_cycle();
    checks++;
    if (gap_q.size() != 3) begin
      failures++; $display("FAIL frame_count got=%0d exp=3", gap_q.size());
    end
    foreach (gap_q[i]) begin
      checks++;
      if (gap_q[i] != FRAME) begin
        failures++; $display("FAIL frame_gap got=%0d exp=%0d", gap_q[i], FRAME);
      end
    end
    foreach (lines_q[i]) begin
      checks++;
      if (lines_q[i] != H) begin
        failures++; $display("FAIL lines_per_frame got=%0d exp=%0d", lines_q[i], H);
      end
    end
    checks++;
    if (bad_runs != 0) begin
      failures++; $display("FAIL line_length got bad=%0d exp=0", bad_runs);
    end
  endtask

  task automatic test_collision_next();
    for (int i = 0; i < 5000 && !(pix_valid === 1'b1 && pix_x === 8'd10 && pix_y === 7'd20); i++) sb_cycle();
    checks++;
    if (pix_valid !== 1'b1 || pix_colour !== 3'b001) begin
      failures++; $display("FAIL collision_new got v=%b c=%b exp v=1 c=001", pix_valid, pix_colour);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] cols [4] = '{8'd50, 8'd99, 8'd100, 8'd150};
    logic [2:0] seen [4] = '{3'b101, 3'b101, 3'b101, 3'b101};
    logic [2:0] want [4] = '{3'b111, 3'b111, 3'b000, 3'b000};
    for (int k = 0; k < 4; k++) begin
      plot = 1'b1; x = cols[k]; y = 7'd0; colour = 3'b000;
      sb_cycle();
    end
    plot = 1'b0;
    clear_req = 1'b1;
    sb_cycle();
    clear_req = 1'b0;
    repeat (100) sb_cycle();
    resetn = 1'b0;
    sb_cycle();
    checks++;
    if (busy !== 1'b0 || oob_err !== 1'b0 || wr_dropped !== 1'b0) begin
      failures++; $display("FAIL abort_flags got busy=%b oob=%b drop=%b exp 0 0 0", busy, oob_err, wr_dropped);
    end
    resetn = 1'b1;
    for (int i = 0; i < 400 && !(pix_valid === 1'b1 && pix_x === 8'd150 && pix_y === 7'd0); i++) begin
      sb_cycle();
      for (int k = 0; k < 4; k++)
        if (pix_valid === 1'b1 && pix_y === 7'd0 && pix_x === cols[k]) seen[k] = pix_colour;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seen[k] !== want[k]) begin
        failures++; $display("FAIL partial_clear x=%0d got=%b exp=%b", cols[k], seen[k], want[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_clear_frame();
    test_write();
    test_oob();
    test_readback();
    test_collision();
    test_timing();
    test_collision_next();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
